// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel stream engine.
//   state_t        : frame FSM encoding (IDLE -> LOAD -> COMPUTE -> DONE)
//   ANG_*          : quantised gradient-direction codes driven on angle_out
//   TAN_NUM/TAN_SH : tan(22.5 deg) ~= 13/32, used for the sector split of the angle
package sobel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [1:0] ANG_0   = 2'd0;
    localparam logic [1:0] ANG_45  = 2'd1;
    localparam logic [1:0] ANG_90  = 2'd2;
    localparam logic [1:0] ANG_135 = 2'd3;

    localparam int TAN_NUM = 13;
    localparam int TAN_SH  = 5;

endpackage

// File: rtl/sobel_kernel.sv
// Purely combinational 3x3 Sobel operator.
//   win_i   : nine pixels, p(R,C) at slot R*3+C (R = row offset, C = column offset
//             from the top-left corner of the window), slot 0 at the LSBs
//   grad_o  : min((|Gx|+|Gy|) >> MAG_SHIFT, 2^PIX_W-1)
//   angle_o : 0/45/90/135 degree sector of the gradient direction
module sobel_kernel
    import sobel_pkg::*;
#(
    parameter int PIX_W     = 5,
    parameter int MAG_SHIFT = 3
) (
    input  logic [9*PIX_W-1:0] win_i,
    output logic [PIX_W-1:0]   grad_o,
    output logic [1:0]         angle_o
);

    // |Gx|,|Gy| <= 4*(2^PIX_W-1), so PIX_W+4 signed bits hold either gradient and
    // their absolute sum; the angle products need TAN_SH more bits.
    localparam int SW = PIX_W + 4;
    localparam int CW = SW + TAN_SH;
    localparam logic [SW-1:0] GRAD_MAX = SW'((1 << PIX_W) - 1);

    logic signed [SW-1:0] p [9];

    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_pix
            assign p[gi] = $signed({{(SW-PIX_W){1'b0}}, win_i[gi*PIX_W +: PIX_W]});
        end
    endgenerate

    logic signed [SW-1:0] gx;
    logic signed [SW-1:0] gy;
    logic [SW-1:0]        ax;
    logic [SW-1:0]        ay;
    logic [SW-1:0]        mag;
    logic [SW-1:0]        mag_sh;
    logic [CW-1:0]        ax_sh;
    logic [CW-1:0]        ay_sh;
    logic [CW-1:0]        ax_tan;
    logic [CW-1:0]        ay_tan;

    assign gx = (p[2] + (p[5] <<< 1) + p[8]) - (p[0] + (p[3] <<< 1) + p[6]);
    assign gy = (p[6] + (p[7] <<< 1) + p[8]) - (p[0] + (p[1] <<< 1) + p[2]);

    assign ax = gx[SW-1] ? $unsigned(-gx) : $unsigned(gx);
    assign ay = gy[SW-1] ? $unsigned(-gy) : $unsigned(gy);

    assign mag    = ax + ay;
    assign mag_sh = mag >> MAG_SHIFT;
    assign grad_o = (mag_sh > GRAD_MAX) ? GRAD_MAX[PIX_W-1:0] : mag_sh[PIX_W-1:0];

    assign ax_sh  = CW'(ax) << TAN_SH;
    assign ay_sh  = CW'(ay) << TAN_SH;
    assign ax_tan = CW'(TAN_NUM) * CW'(ax);
    assign ay_tan = CW'(TAN_NUM) * CW'(ay);

    // Mostly-horizontal gradient first; a zero gradient falls into this branch too.
    // The diagonal branches are only reached with both gradients non-zero, so the
    // sign bits are meaningful there.
    always_comb begin
        angle_o = ANG_0;
        if (ay_sh <= ax_tan) begin
            angle_o = ANG_0;
        end else if (ax_sh <= ay_tan) begin
            angle_o = ANG_90;
        end else if (gx[SW-1] == gy[SW-1]) begin
            angle_o = ANG_45;
        end else begin
            angle_o = ANG_135;
        end
    end

endmodule

// File: rtl/sobel_stream_engine.sv
// Frame-buffered Sobel edge stage.
// Loads one IMG_W x IMG_H frame as LANES pixels per valid beat, then emits one 3x3
// window result per cycle in raster order over all interior centres.
//   clk, reset             : clock, asynchronous active-high reset
//   in_valid, load_end     : beat strobe and last-beat marker (load_end needs in_valid)
//   pixel_in               : LANES pixels, lane 0 at the LSBs = leftmost column of the beat
//   readable               : grad_out/angle_out/edge_out carry a result this cycle
//   grad_out, angle_out    : saturated magnitude and quantised direction
//   edge_out               : grad_out >= EDGE_TH
//   frame_done             : one-cycle pulse after the last result
//   load_err               : beat count of the current frame differed from IMG_W*IMG_H/LANES
module sobel_stream_engine
    import sobel_pkg::*;
#(
    parameter int PIX_W     = 5,
    parameter int LANES     = 5,
    parameter int IMG_W     = 20,
    parameter int IMG_H     = 20,
    parameter int MAG_SHIFT = 3,
    parameter int EDGE_TH   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic                   load_end,
    input  logic [LANES*PIX_W-1:0] pixel_in,
    output logic                   readable,
    output logic [PIX_W-1:0]       grad_out,
    output logic [1:0]             angle_out,
    output logic                   edge_out,
    output logic                   frame_done,
    output logic                   load_err
);

    localparam int BPR   = IMG_W / LANES;
    localparam int TOTAL = IMG_H * BPR;
    localparam int RW    = $clog2(IMG_H);
    localparam int CLW   = $clog2(IMG_W);
    localparam int BCW   = (BPR > 1) ? $clog2(BPR) : 1;
    localparam int BW    = $clog2(TOTAL + 1);

    // Frame store: not reset, a new frame simply overwrites it.
    logic [PIX_W-1:0] frame_q [IMG_H][IMG_W];

    state_t           state_q, state_d;
    logic [BW-1:0]    beat_cnt_q, beat_cnt_d;
    logic [RW-1:0]    brow_q, brow_d;
    logic [BCW-1:0]   bcol_q, bcol_d;
    logic [RW-1:0]    wrow_q, wrow_d;
    logic [CLW-1:0]   wcol_q, wcol_d;
    logic             err_q, err_d;
    logic             readable_q, readable_d;
    logic [PIX_W-1:0] grad_q, grad_d;
    logic [1:0]       angle_q, angle_d;
    logic             edge_q, edge_d;
    logic             done_q, done_d;

    logic             wr_en;
    logic [CLW-1:0]   col_base;
    logic [9*PIX_W-1:0] win;
    logic [PIX_W-1:0] k_grad;
    logic [1:0]       k_angle;

    assign col_base = CLW'(bcol_q) * CLW'(LANES);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < LANES; k++) begin
                frame_q[brow_q][col_base + CLW'(k)] <= pixel_in[k*PIX_W +: PIX_W];
            end
        end
    end

    // 3x3 neighbourhood around the current window centre (wrow_q, wcol_q).
    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_win
            assign win[gi*PIX_W +: PIX_W] =
                frame_q[wrow_q + RW'(gi / 3) - RW'(1)][wcol_q + CLW'(gi % 3) - CLW'(1)];
        end
    endgenerate

    sobel_kernel #(
        .PIX_W     (PIX_W),
        .MAG_SHIFT (MAG_SHIFT)
    ) u_kernel (
        .win_i   (win),
        .grad_o  (k_grad),
        .angle_o (k_angle)
    );

    // Beat counters are always zero in IDLE (cleared on load_end and by reset), so
    // the first beat of a frame lands at row 0, column 0 without special casing.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        brow_d     = brow_q;
        bcol_d     = bcol_q;
        wrow_d     = wrow_q;
        wcol_d     = wcol_q;
        err_d      = err_q;
        wr_en      = 1'b0;
        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (in_valid) begin
                    if (state_q == ST_IDLE) begin
                        err_d = 1'b0;
                    end
                    if (beat_cnt_q == BW'(TOTAL)) begin
                        // frame already full: drop the beat
                        err_d = 1'b1;
                    end else begin
                        wr_en      = 1'b1;
                        beat_cnt_d = beat_cnt_q + 1'b1;
                        if (bcol_q == BCW'(BPR - 1)) begin
                            bcol_d = '0;
                            brow_d = brow_q + 1'b1;
                        end else begin
                            bcol_d = bcol_q + 1'b1;
                        end
                    end
                    if (load_end) begin
                        if (beat_cnt_q != BW'(TOTAL - 1)) begin
                            err_d = 1'b1;
                        end
                        state_d    = ST_COMPUTE;
                        beat_cnt_d = '0;
                        brow_d     = '0;
                        bcol_d     = '0;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_COMPUTE: begin
                if (wcol_q == CLW'(IMG_W - 2)) begin
                    wcol_d = CLW'(1);
                    if (wrow_q == RW'(IMG_H - 2)) begin
                        wrow_d  = RW'(1);
                        state_d = ST_DONE;
                    end else begin
                        wrow_d = wrow_q + 1'b1;
                    end
                end else begin
                    wcol_d = wcol_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output stage: the window addressed during COMPUTE is registered on the same
    // edge that advances the window counter; data is forced to zero when idle.
    always_comb begin
        readable_d = (state_q == ST_COMPUTE);
        grad_d     = readable_d ? k_grad : '0;
        angle_d    = readable_d ? k_angle : ANG_0;
        edge_d     = readable_d && (int'(k_grad) >= EDGE_TH);
        done_d     = (state_q == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            brow_q     <= '0;
            bcol_q     <= '0;
            wrow_q     <= RW'(1);
            wcol_q     <= CLW'(1);
            err_q      <= 1'b0;
            readable_q <= 1'b0;
            grad_q     <= '0;
            angle_q    <= ANG_0;
            edge_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            brow_q     <= brow_d;
            bcol_q     <= bcol_d;
            wrow_q     <= wrow_d;
            wcol_q     <= wcol_d;
            err_q      <= err_d;
            readable_q <= readable_d;
            grad_q     <= grad_d;
            angle_q    <= angle_d;
            edge_q     <= edge_d;
            done_q     <= done_d;
        end
    end

    assign readable   = readable_q;
    assign grad_out   = grad_q;
    assign angle_out  = angle_q;
    assign edge_out   = edge_q;
    assign frame_done = done_q;
    assign load_err   = err_q;

endmodule

// File: tb/tb_sobel_stream_engine.sv
module tb_sobel_stream_engine;

    localparam int PIX_W = 5;
    localparam int LANES = 5;
    localparam int IMG_W = 20;
    localparam int IMG_H = 20;
    localparam int BPR   = IMG_W / LANES;
    localparam int TOTAL = IMG_H * BPR;
    localparam int NWIN  = (IMG_H - 2) * (IMG_W - 2);

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic                   load_end;
    logic [LANES*PIX_W-1:0] pixel_in;
    logic                   readable;
    logic [PIX_W-1:0]       grad_out;
    logic [1:0]             angle_out;
    logic                   edge_out;
    logic                   frame_done;
    logic                   load_err;

    int checks = 0;
    int errors = 0;

    int               img [IMG_H][IMG_W];
    logic [PIX_W-1:0] res_g [NWIN];
    logic [1:0]       res_a [NWIN];
    logic             res_e [NWIN];
    int               n_res, first_cyc, done_cyc, n_done, n_gaps, n_dirty;
    bit               timed_out;

    always #5 clk = ~clk;

    sobel_stream_engine #(
        .PIX_W(PIX_W), .LANES(LANES), .IMG_W(IMG_W), .IMG_H(IMG_H),
        .MAG_SHIFT(3), .EDGE_TH(8)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .load_end(load_end),
        .pixel_in(pixel_in), .readable(readable), .grad_out(grad_out),
        .angle_out(angle_out), .edge_out(edge_out), .frame_done(frame_done),
        .load_err(load_err)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic fill_flat(input int v);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) img[r][c] = v;
    endtask

    // Beats with a higher index than the frame holds carry all-ones pixels.
    task automatic drive_frame(input int nbeats, input int end_beat, input bit stall);
        for (int b = 0; b < nbeats; b++) begin
            if (stall) begin
                in_valid = 1'b0;
                load_end = 1'b1;
                pixel_in = '1;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            load_end = (b + 1 == end_beat);
            for (int k = 0; k < LANES; k++) begin
                if (b < TOTAL) pixel_in[k*PIX_W +: PIX_W] = PIX_W'(img[b / BPR][(b % BPR) * LANES + k]);
                else           pixel_in[k*PIX_W +: PIX_W] = '1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        load_end = 1'b0;
        pixel_in = '0;
    endtask

    // Records one frame's results; cycle 1 is the cycle after the load_end edge.
    task automatic collect();
        int last;
        n_res = 0; first_cyc = -1; done_cyc = -1; n_done = 0; n_gaps = 0; n_dirty = 0;
        timed_out = 1'b1; last = -10;
        for (int i = 0; i < NWIN; i++) begin
            res_g[i] = 'x; res_a[i] = 'x; res_e[i] = 1'bx;
        end
        for (int cyc = 1; cyc <= NWIN + 40; cyc++) begin
            @(posedge clk); #1;
            if (readable === 1'b1) begin
                if (first_cyc < 0) first_cyc = cyc;
                else if (cyc != last + 1) n_gaps++;
                last = cyc;
                if (n_res < NWIN) begin
                    res_g[n_res] = grad_out; res_a[n_res] = angle_out; res_e[n_res] = edge_out;
                end
                n_res++;
            end else if (grad_out !== '0 || angle_out !== 2'd0 || edge_out !== 1'b0) begin
                n_dirty++;
            end
            if (frame_done === 1'b1) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc > done_cyc) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; load_end = 1'b0; pixel_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({readable, grad_out, angle_out, edge_out, frame_done, load_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rd=%b g=%0d a=%0d e=%b fd=%b le=%b, want all 0",
                     readable, grad_out, angle_out, edge_out, frame_done, load_err);
        end
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (readable !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got rd=%b fd=%b, want 0 0", readable, frame_done);
        end
    endtask

    task automatic test_flat();
        fill_flat(17);
        drive_frame(TOTAL, TOTAL, 1'b0);
        collect();
        checks++;
        if (timed_out || n_res != NWIN || first_cyc != 1 || n_gaps != 0 || n_done != 1 || done_cyc != NWIN + 1 || n_dirty != 0) begin
            errors++;
            $display("FAIL flat_stats: res=%0d first=%0d gaps=%0d done=%0d@%0d dirty=%0d to=%0d, want 324/1/0/1@325/0/0",
                     n_res, first_cyc, n_gaps, n_done, done_cyc, n_dirty, timed_out);
        end
        checks++;
        if (load_err !== 1'b0) begin
            errors++; $display("FAIL flat_load_err: got %b want 0", load_err);
        end
        for (int w = 0; w < NWIN; w++) begin
            checks++;
            if ({res_g[w], res_a[w], res_e[w]} !== 8'd0) begin
                errors++;
                $display("FAIL flat_win w=%0d: got g=%0d a=%0d e=%b want 0 0 0", w, res_g[w], res_a[w], res_e[w]);
            end
        end
    endtask

    task automatic test_vstep();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) img[r][c] = (c < 10) ? 0 : 31;
        drive_frame(TOTAL, TOTAL, 1'b0);
        collect();
        checks++;
        if (timed_out || n_res != NWIN || first_cyc != 1 || n_gaps != 0 || n_done != 1 || done_cyc != NWIN + 1 || n_dirty != 0) begin
            errors++;
            $display("FAIL vstep_stats: res=%0d first=%0d gaps=%0d done=%0d@%0d dirty=%0d to=%0d, want 324/1/0/1@325/0/0",
                     n_res, first_cyc, n_gaps, n_done, done_cyc, n_dirty, timed_out);
        end
        for (int w = 0; w < NWIN; w++) begin
            int r = 1 + w / (IMG_W - 2);
            int c = 1 + w % (IMG_W - 2);
            logic [4:0] eg = (c == 9 || c == 10) ? 5'd15 : 5'd0;
            logic       ee = (c == 9 || c == 10);
            checks++;
            if ({res_g[w], res_a[w], res_e[w]} !== {eg, 2'd0, ee}) begin
                errors++;
                $display("FAIL vstep_win r=%0d c=%0d: got g=%0d a=%0d e=%b want g=%0d a=0 e=%b",
                         r, c, res_g[w], res_a[w], res_e[w], eg, ee);
            end
        end
    endtask

    task automatic test_hstep();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) img[r][c] = (r < 10) ? 0 : 31;
        drive_frame(TOTAL, TOTAL, 1'b0);
        collect();
        checks++;
        if (timed_out || n_res != NWIN || first_cyc != 1 || n_gaps != 0 || n_done != 1 || done_cyc != NWIN + 1 || n_dirty != 0) begin
            errors++;
            $display("FAIL hstep_stats: res=%0d first=%0d gaps=%0d done=%0d@%0d dirty=%0d to=%0d, want 324/1/0/1@325/0/0",
                     n_res, first_cyc, n_gaps, n_done, done_cyc, n_dirty, timed_out);
        end
        for (int w = 0; w < NWIN; w++) begin
            int r = 1 + w / (IMG_W - 2);
            int c = 1 + w % (IMG_W - 2);
            bit on = (r == 9 || r == 10);
            logic [4:0] eg = on ? 5'd15 : 5'd0;
            logic [1:0] ea = on ? 2'd2 : 2'd0;
            checks++;
            if ({res_g[w], res_a[w], res_e[w]} !== {eg, ea, on}) begin
                errors++;
                $display("FAIL hstep_win r=%0d c=%0d: got g=%0d a=%0d e=%b want g=%0d a=%0d e=%b",
                         r, c, res_g[w], res_a[w], res_e[w], eg, ea, on);
            end
        end
    endtask

    // Ramps clipped to the pixel range; only windows whose nine pixels are unclipped are checked.
    task automatic test_diagonals();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) img[r][c] = (r + c > 31) ? 31 : r + c;
        drive_frame(TOTAL, TOTAL, 1'b0);
        collect();
        checks++;
        if (timed_out || n_res != NWIN || n_done != 1) begin
            errors++;
            $display("FAIL diag_stats: res=%0d done=%0d to=%0d, want 324/1/0", n_res, n_done, timed_out);
        end
        for (int w = 0; w < NWIN; w++) begin
            int r = 1 + w / (IMG_W - 2);
            int c = 1 + w % (IMG_W - 2);
            if (r + c <= 29) begin
                checks++;
                if ({res_g[w], res_a[w], res_e[w]} !== {5'd2, 2'd1, 1'b0}) begin
                    errors++;
                    $display("FAIL diag_win r=%0d c=%0d: got g=%0d a=%0d e=%b want g=2 a=1 e=0",
                             r, c, res_g[w], res_a[w], res_e[w]);
                end
            end
        end
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) begin
                int v = c - r + 19;
                img[r][c] = (v > 31) ? 31 : ((v < 0) ? 0 : v);
            end
        drive_frame(TOTAL, TOTAL, 1'b0);
        collect();
        checks++;
        if (timed_out || n_res != NWIN || n_done != 1) begin
            errors++;
            $display("FAIL anti_stats: res=%0d done=%0d to=%0d, want 324/1/0", n_res, n_done, timed_out);
        end
        for (int w = 0; w < NWIN; w++) begin
            int r = 1 + w / (IMG_W - 2);
            int c = 1 + w % (IMG_W - 2);
            if (c - r <= 10 && c - r >= -17) begin
                checks++;
                if ({res_g[w], res_a[w], res_e[w]} !== {5'd2, 2'd3, 1'b0}) begin
                    errors++;
                    $display("FAIL anti_win r=%0d c=%0d: got g=%0d a=%0d e=%b want g=2 a=3 e=0",
                             r, c, res_g[w], res_a[w], res_e[w]);
                end
            end
        end
    endtask

    task automatic test_stall();
        fill_flat(17);
        drive_frame(TOTAL, TOTAL, 1'b1);
        collect();
        checks++;
        if (timed_out || n_res != NWIN || first_cyc != 1 || n_gaps != 0 || n_done != 1 || done_cyc != NWIN + 1 || n_dirty != 0) begin
            errors++;
            $display("FAIL stall_stats: res=%0d first=%0d gaps=%0d done=%0d@%0d dirty=%0d to=%0d, want 324/1/0/1@325/0/0",
                     n_res, first_cyc, n_gaps, n_done, done_cyc, n_dirty, timed_out);
        end
        checks++;
        if (load_err !== 1'b0) begin
            errors++; $display("FAIL stall_load_err: got %b want 0", load_err);
        end
        for (int w = 0; w < NWIN; w++) begin
            checks++;
            if ({res_g[w], res_a[w], res_e[w]} !== 8'd0) begin
                errors++;
                $display("FAIL stall_win w=%0d: got g=%0d a=%0d e=%b want 0 0 0", w, res_g[w], res_a[w], res_e[w]);
            end
        end
    endtask

    // Runs right after test_stall, so the buffer holds flat 17 before the short frame.
    task automatic test_load_err();
        // 60 beats of zeros overwrite rows 0..14; rows 15..19 keep 17 -> Gy=68, grad=8.
        fill_flat(0);
        drive_frame(60, 60, 1'b0);
        collect();
        checks++;
        if (timed_out || n_res != NWIN || first_cyc != 1 || n_gaps != 0 || n_done != 1) begin
            errors++;
            $display("FAIL short_stats: res=%0d first=%0d gaps=%0d done=%0d to=%0d, want 324/1/0/1/0",
                     n_res, first_cyc, n_gaps, n_done, timed_out);
        end
        checks++;
        if (load_err !== 1'b1) begin
            errors++; $display("FAIL short_load_err: got %b want 1", load_err);
        end
        for (int w = 0; w < NWIN; w++) begin
            int r = 1 + w / (IMG_W - 2);
            bit on = (r == 14 || r == 15);
            logic [4:0] eg = on ? 5'd8 : 5'd0;
            logic [1:0] ea = on ? 2'd2 : 2'd0;
            checks++;
            if ({res_g[w], res_a[w], res_e[w]} !== {eg, ea, on}) begin
                errors++;
                $display("FAIL short_win w=%0d r=%0d: got g=%0d a=%0d e=%b want g=%0d a=%0d e=%b",
                         w, r, res_g[w], res_a[w], res_e[w], eg, ea, on);
            end
        end
        // Full frame clears the flag.
        drive_frame(TOTAL, TOTAL, 1'b0);
        collect();
        checks++;
        if (load_err !== 1'b0 || n_res != NWIN || n_done != 1) begin
            errors++;
            $display("FAIL recover_load_err: got le=%b res=%0d done=%0d want 0/324/1", load_err, n_res, n_done);
        end
        // 85 beats: the five extra all-ones beats must be dropped.
        fill_flat(5);
        drive_frame(TOTAL + 5, TOTAL + 5, 1'b0);
        collect();
        checks++;
        if (load_err !== 1'b1 || timed_out || n_res != NWIN || first_cyc != 1 || n_done != 1) begin
            errors++;
            $display("FAIL long_stats: le=%b res=%0d first=%0d done=%0d to=%0d, want 1/324/1/1/0",
                     load_err, n_res, first_cyc, n_done, timed_out);
        end
        for (int w = 0; w < NWIN; w++) begin
            checks++;
            if ({res_g[w], res_a[w], res_e[w]} !== 8'd0) begin
                errors++;
                $display("FAIL long_win w=%0d: got g=%0d a=%0d e=%b want 0 0 0", w, res_g[w], res_a[w], res_e[w]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) img[r][c] = (c < 10) ? 0 : 31;
        drive_frame(TOTAL, TOTAL, 1'b0);
        for (int cyc = 0; cyc < 400 && seen < 100; cyc++) begin
            @(posedge clk); #1;
            if (readable === 1'b1) seen++;
        end
        checks++;
        if (seen != 100) begin
            errors++; $display("FAIL midreset_reach: got %0d results before reset, want 100", seen);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({readable, grad_out, angle_out, edge_out, frame_done, load_err} !== '0) begin
            errors++;
            $display("FAIL midreset_async: got rd=%b g=%0d a=%0d e=%b fd=%b le=%b, want all 0",
                     readable, grad_out, angle_out, edge_out, frame_done, load_err);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (readable !== 1'b0 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL midreset_idle cyc%0d: got rd=%b fd=%b want 0 0", i, readable, frame_done);
            end
        end
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) img[r][c] = (r < 10) ? 0 : 31;
        drive_frame(TOTAL, TOTAL, 1'b0);
        collect();
        checks++;
        if (timed_out || n_res != NWIN || first_cyc != 1 || n_gaps != 0 || n_done != 1 || done_cyc != NWIN + 1 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_stats: res=%0d first=%0d gaps=%0d done=%0d@%0d le=%b to=%0d, want 324/1/0/1@325/0/0",
                     n_res, first_cyc, n_gaps, n_done, done_cyc, load_err, timed_out);
        end
        for (int w = 0; w < NWIN; w++) begin
            int r = 1 + w / (IMG_W - 2);
            bit on = (r == 9 || r == 10);
            logic [4:0] eg = on ? 5'd15 : 5'd0;
            logic [1:0] ea = on ? 2'd2 : 2'd0;
            checks++;
            if ({res_g[w], res_a[w], res_e[w]} !== {eg, ea, on}) begin
                errors++;
                $display("FAIL midreset_win w=%0d: got g=%0d a=%0d e=%b want g=%0d a=%0d e=%b",
                         w, res_g[w], res_a[w], res_e[w], eg, ea, on);
            end
        end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_vstep();
        test_hstep();
        test_diagonals();
        test_stall();
        test_load_err();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
